// File: rtl/matrix_exec_seq_if.sv
// Single-port synchronous memory bus used by matrix_exec_seq.
// The master drives address, write data and write enable; the memory returns read data.
interface matrix_exec_seq_if #(
  parameter int AW = 8,
  parameter int DW = 40
) ();
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/matrix_exec_seq.sv
// Matrix coprocessor sequencer: fetches instruction and DIM x DIM operands row by row,
// executes an element-wise/transpose op and writes result rows back. Define MATRIX_EXEC_SAT_EN to saturate.
module matrix_exec_seq #(
  parameter int EW     = 8,
  parameter int DIM    = 5,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AW-1:0]           base_addr,
  matrix_exec_seq_if.master       mem,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    err,
  output logic [2:0]              state_o
);

  localparam int DW = DIM * EW;
  localparam int FW = 2 * EW + 1;
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_F_INS = 3'd1;
  localparam logic [2:0] S_F_A   = 3'd2;
  localparam logic [2:0] S_F_B   = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_SMUL  = 3'b011;
  localparam logic [2:0] OP_TRANS = 3'b101;
  localparam logic [2:0] OP_NEG   = 3'b110;

  localparam logic [RW-1:0] LAST_ROW = RW'(DIM - 1);
  localparam logic [2:0]    LAT_W    = 3'(RD_LAT);
  localparam logic [AW-1:0] OFF_A    = AW'(1);
  localparam logic [AW-1:0] OFF_B    = AW'(DIM + 1);
  localparam logic [AW-1:0] OFF_R    = AW'(2 * DIM + 1);

  logic [2:0]           state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [2:0]           wait_q, wait_d;
  logic [AW-1:0]        base_q, base_d;
  logic [2:0]           opc_q, opc_d;
  logic signed [EW-1:0] scal_q, scal_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic                 cap_a, cap_b, cap_r;
  logic                 fetch_last;
  logic                 exec_ovf;
  logic [DW-1:0]        wrow;

  logic signed [EW-1:0] a_q [DIM][DIM];
  logic signed [EW-1:0] b_q [DIM][DIM];
  logic signed [EW-1:0] r_q [DIM][DIM];
  logic [EW:0]          res_w [DIM][DIM];

  // Returns {overflow, value}; value is the truncated (or clamped) EW-bit result.
  function automatic logic [EW:0] fit(input logic signed [FW-1:0] full);
    logic signed [EW-1:0] t;
    logic                 ovf;
    t   = full[EW-1:0];
    ovf = (FW'(t) != full);
`ifdef MATRIX_EXEC_SAT_EN
    if (ovf) t = full[FW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
`endif
    return {ovf, t};
  endfunction

  function automatic logic [EW:0] elem_op(input logic [2:0] op,
                                          input logic signed [EW-1:0] a,
                                          input logic signed [EW-1:0] b,
                                          input logic signed [EW-1:0] at,
                                          input logic signed [EW-1:0] s);
    logic signed [FW-1:0] ax, bx, sx;
    logic [EW:0]          res;
    ax = FW'(a);
    bx = FW'(b);
    sx = FW'(s);
    case (op)
      OP_ADD:  res = fit(ax + bx);
      OP_SUB:  res = fit(ax - bx);
      OP_SMUL: res = fit(ax * sx);
      OP_NEG:  res = fit(-ax);
      default: res = {1'b0, at};
    endcase
    return res;
  endfunction

  function automatic logic legal_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SMUL) ||
           (op == OP_TRANS) || (op == OP_NEG);
  endfunction

  always_comb begin
    exec_ovf = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        res_w[r][c] = elem_op(opc_q, a_q[r][c], b_q[r][c], a_q[c][r], scal_q);
        exec_ovf    = exec_ovf | res_w[r][c][EW];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    wait_d     = wait_q;
    base_d     = base_q;
    opc_d      = opc_q;
    scal_d     = scal_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_r      = 1'b0;
    fetch_last = (wait_q == LAT_W);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          row_d   = '0;
          wait_d  = '0;
          state_d = S_F_INS;
        end
      end
      S_F_INS: begin
        if (fetch_last) begin
          wait_d  = '0;
          opc_d   = mem.mem_rdata[2:0];
          scal_d  = mem.mem_rdata[EW+7:8];
          err_d   = !legal_op(mem.mem_rdata[2:0]);
          state_d = legal_op(mem.mem_rdata[2:0]) ? S_F_A : S_DONE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_F_A, S_F_B: begin
        if (fetch_last) begin
          wait_d = '0;
          cap_a  = (state_q == S_F_A);
          cap_b  = (state_q == S_F_B);
          if (row_q == LAST_ROW) begin
            row_d = '0;
            // Only the binary ops need the second operand fetched.
            if (state_q == S_F_A && (opc_q == OP_ADD || opc_q == OP_SUB)) state_d = S_F_B;
            else                                                          state_d = S_EXEC;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_EXEC: begin
        cap_r   = 1'b1;
        ovf_d   = ovf_q | exec_ovf;
        row_d   = '0;
        state_d = S_WB;
      end
      S_WB: begin
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = S_DONE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      wait_q  <= '0;
      base_q  <= '0;
      opc_q   <= '0;
      scal_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wait_q  <= wait_d;
      base_q  <= base_d;
      opc_q   <= opc_d;
      scal_q  <= scal_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          r_q[r][c] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < DIM; c++) begin
        if (cap_a) a_q[row_q][c] <= mem.mem_rdata[(DIM-c)*EW-1 -: EW];
        if (cap_b) b_q[row_q][c] <= mem.mem_rdata[(DIM-c)*EW-1 -: EW];
      end
      if (cap_r) begin
        for (int r = 0; r < DIM; r++) begin
          for (int c = 0; c < DIM; c++) r_q[r][c] <= res_w[r][c][EW-1:0];
        end
      end
    end
  end

  always_comb begin
    mem.mem_addr = '0;
    case (state_q)
      S_F_INS: mem.mem_addr = base_q;
      S_F_A:   mem.mem_addr = base_q + OFF_A + AW'(row_q);
      S_F_B:   mem.mem_addr = base_q + OFF_B + AW'(row_q);
      S_WB:    mem.mem_addr = base_q + OFF_R + AW'(row_q);
      default: mem.mem_addr = '0;
    endcase
  end

  // Column 0 occupies the most significant element slot of a row word.
  always_comb begin
    wrow = '0;
    if (state_q == S_WB) begin
      for (int c = 0; c < DIM; c++) wrow[(DIM-c)*EW-1 -: EW] = r_q[row_q][c];
    end
  end

  assign mem.mem_wdata = wrow;
  assign mem.mem_we    = (state_q == S_WB);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign overflow      = ovf_q;
  assign err           = err_q;
  assign state_o       = state_q;

endmodule
